// File: rtl/cpu_run_ctrl.sv
// Run controller for the simulated MIPS core: stretches reset into a core reset
// pulse, counts cycles/retirements, and flags program end (jump-to-self) or timeout.
module cpu_run_ctrl #(
  parameter int PC_W        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 2,
  parameter int MAX_CYCLES  = 100000,
  parameter int HALT_REPEAT = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             restart,
  input  logic             retire,
  input  logic [PC_W-1:0]  retire_pc,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [PC_W-1:0]  halt_pc,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int REP_W = $clog2(HALT_REPEAT);

  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(HALT_REPEAT - 2);

  typedef enum logic [1:0] {
    RST_HOLD,
    RUN,
    HALTED,
    TIMEOUT
  } state_t;

  state_t           state;
  logic [RST_W-1:0] rst_cnt;
  logic [REP_W-1:0] rep_cnt;
  logic [PC_W-1:0]  last_pc;
  logic             last_pc_valid;

  logic pc_match;
  logic halt_hit;
  logic budget_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // rep_cnt counts repeats after the first sighting, so the halt fires on the
  // HALT_REPEAT-th consecutive retirement of the same PC.
  assign pc_match   = retire && last_pc_valid && (retire_pc == last_pc);
  assign halt_hit   = pc_match && (rep_cnt == REP_LAST);
  assign budget_hit = (cycle_cnt == CYC_LAST);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      state         <= RST_HOLD;
      rst_cnt       <= '0;
      core_reset    <= 1'b1;
      running       <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      halt_pc       <= '0;
      cycle_cnt     <= '0;
      instr_cnt     <= '0;
      last_pc       <= '0;
      last_pc_valid <= 1'b0;
      rep_cnt       <= '0;
    end else begin
      case (state)
        RST_HOLD: begin
          rst_cnt <= rst_cnt + RST_W'(1);
          if (rst_cnt == RST_LAST) begin
            state      <= RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end
        end
        RUN: begin
          cycle_cnt <= sat_inc(cycle_cnt);
          if (retire) begin
            instr_cnt     <= sat_inc(instr_cnt);
            rep_cnt       <= pc_match ? rep_cnt + REP_W'(1) : '0;
            last_pc       <= retire_pc;
            last_pc_valid <= 1'b1;
          end
          // A halt on the budget edge takes precedence over the timeout.
          if (halt_hit) begin
            state   <= HALTED;
            running <= 1'b0;
            done    <= 1'b1;
            halt_pc <= retire_pc;
          end else if (budget_hit) begin
            state   <= TIMEOUT;
            running <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
